game_flow_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 29 ++
 rtl/key_press_detect.sv | 33 +++
 rtl/game_flow_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow sequencer.
//   game_state_t : screen/state encoding (3 bits; codes 6 and 7 are unused)
//   KEY_SPACE    : keycode of the space bar
//   KEY_P        : keycode of the P key
//   LIVES_W      : width of the lives counter
//   LEVEL_W      : width of the level counter
//   max_int      : larger of two integers, used to size the shared counter
package game_pkg;

  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_PLAY     = 3'd1,
    S_PAUSE    = 3'd2,
    S_RESPAWN  = 3'd3,
    S_GAMEOVER = 3'd4,
    S_WIN      = 3'd5
  } game_state_t;

  localparam logic [7:0] KEY_SPACE = 8'h2c;
  localparam logic [7:0] KEY_P     = 8'h13;

  localparam int LIVES_W = 4;
  localparam int LEVEL_W = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// Rising-edge detector for one keyboard keycode.
// A press is flagged in the first cycle the keycode equals KEY; holding the
// key produces no further presses until it is released and pressed again.
//   Clk     : system clock
//   Reset_n : asynchronous active-low reset
//   keycode : current keycode, 8'h00 when no key is down
//   press   : high for one cycle when KEY is newly pressed
module key_press_detect
  import game_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_SPACE
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  output logic       press
);

  logic [7:0] keycode_p0;

  // Stage 0: previous keycode. Resetting to "no key" makes a key that is
  // already held when reset releases count as a fresh press.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keycode_p0 <= 8'h00;
    end else begin
      keycode_p0 <= keycode;
    end
  end

  assign press = (keycode == KEY) && (keycode_p0 != KEY);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: chooses the active screen (start, play, pause,
// game over, win) and tracks lives and level for the playfield and ghosts.
//   Clk         : system clock
//   Reset_n     : asynchronous active-low reset
//   keycode     : current keyboard keycode, 8'h00 = none
//   life_lost   : one-cycle pulse from collision logic
//   level_clear : one-cycle pulse when all dots are eaten
//   starton     : start screen select
//   playon      : playfield select (PLAY, PAUSE, RESPAWN)
//   freeze      : sprites hold position (PAUSE, RESPAWN)
//   gameoveron  : game-over screen select
//   winon       : win screen select
//   round_init  : one-cycle pulse that re-seeds sprites and dots
//   lives       : lives remaining
//   level       : current level, 0-based
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter logic [7:0] START_KEY = KEY_SPACE,
  parameter logic [7:0] PAUSE_KEY = KEY_P,
  parameter int         LIVES     = 3,
  parameter int         LEVELS    = 4,
  parameter int         COOLDOWN  = 7,
  parameter int         RESPAWN   = 64
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [7:0]         keycode,
  input  logic               life_lost,
  input  logic               level_clear,
  output logic               starton,
  output logic               playon,
  output logic               freeze,
  output logic               gameoveron,
  output logic               winon,
  output logic               round_init,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level
);

  // One down-counter serves both the start-screen cooldown and the respawn
  // freeze, so it is sized for the longer of the two.
  localparam int CNT_W = $clog2(max_int(COOLDOWN, RESPAWN) + 1);

  localparam logic [CNT_W-1:0]   CNT_COOL   = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0]   CNT_RESP   = CNT_W'(RESPAWN);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = '0;
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LEVELS - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);

  logic press_start;
  logic press_pause;

  key_press_detect #(
    .KEY (START_KEY)
  ) u_start_key (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .keycode (keycode),
    .press   (press_start)
  );

  key_press_detect #(
    .KEY (PAUSE_KEY)
  ) u_pause_key (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .keycode (keycode),
    .press   (press_pause)
  );

  game_state_t          state_p0, state_d;
  logic [CNT_W-1:0]     cnt_p0, cnt_d;
  logic [LIVES_W-1:0]   lives_p0, lives_d;
  logic [LEVEL_W-1:0]   level_p0, level_d;
  logic                 round_init_p0, round_init_d;

  // Stage 0: state, counter and game-progress registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_p0      <= S_START;
      cnt_p0        <= CNT_COOL;
      lives_p0      <= LIVES_INIT;
      level_p0      <= '0;
      round_init_p0 <= 1'b0;
    end else begin
      state_p0      <= state_d;
      cnt_p0        <= cnt_d;
      lives_p0      <= lives_d;
      level_p0      <= level_d;
      round_init_p0 <= round_init_d;
    end
  end

  always_comb begin
    state_d      = state_p0;
    cnt_d        = cnt_p0;
    lives_d      = lives_p0;
    level_d      = level_p0;
    round_init_d = 1'b0;

    case (state_p0)
      S_START: begin
        if (cnt_p0 != CNT_ZERO) begin
          cnt_d = cnt_p0 - CNT_ONE;
        end else if (press_start) begin
          state_d      = S_PLAY;
          lives_d      = LIVES_INIT;
          level_d      = '0;
          round_init_d = 1'b1;
        end
      end

      S_PLAY: begin
        // A life lost outranks a simultaneous level clear.
        if (life_lost) begin
          if (lives_p0 <= LIVES_ONE) begin
            state_d = S_GAMEOVER;
            lives_d = '0;
          end else begin
            state_d = S_RESPAWN;
            lives_d = lives_p0 - LIVES_ONE;
            cnt_d   = CNT_RESP;
          end
        end else if (level_clear) begin
          if (level_p0 >= LEVEL_LAST) begin
            state_d = S_WIN;
          end else begin
            level_d      = level_p0 + LEVEL_ONE;
            round_init_d = 1'b1;
          end
        end else if (press_pause) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (press_pause || press_start) begin
          state_d = S_PLAY;
        end
      end

      S_RESPAWN: begin
        // Leaving on count 1 gives a dwell of exactly RESPAWN cycles.
        if (cnt_p0 <= CNT_ONE) begin
          state_d      = S_PLAY;
          round_init_d = 1'b1;
        end else begin
          cnt_d = cnt_p0 - CNT_ONE;
        end
      end

      S_GAMEOVER, S_WIN: begin
        if (press_start) begin
          state_d = S_START;
          cnt_d   = CNT_COOL;
        end
      end

      default: begin
        state_d = S_START;
        cnt_d   = CNT_COOL;
      end
    endcase
  end

  assign starton    = (state_p0 == S_START);
  assign playon     = (state_p0 == S_PLAY) || (state_p0 == S_PAUSE) ||
                      (state_p0 == S_RESPAWN);
  assign freeze     = (state_p0 == S_PAUSE) || (state_p0 == S_RESPAWN);
  assign gameoveron = (state_p0 == S_GAMEOVER);
  assign winon      = (state_p0 == S_WIN);
  assign round_init = round_init_p0;
  assign lives      = lives_p0;
  assign level      = level_p0;

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       life_lost;
  logic       level_clear;
  logic       starton, playon, freeze, gameoveron, winon, round_init;
  logic [3:0] lives;
  logic [3:0] level;

  game_flow_ctrl #(
    .START_KEY (8'h2c),
    .PAUSE_KEY (8'h13),
    .LIVES     (3),
    .LEVELS    (4),
    .COOLDOWN  (7),
    .RESPAWN   (64)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .keycode     (keycode),
    .life_lost   (life_lost),
    .level_clear (level_clear),
    .starton     (starton),
    .playon      (playon),
    .freeze      (freeze),
    .gameoveron  (gameoveron),
    .winon       (winon),
    .round_init  (round_init),
    .lives       (lives),
    .level       (level)
  );

  always #5 Clk = ~Clk;

  // Screen-select patterns: {starton, playon, freeze, gameoveron, winon, round_init}
  localparam logic [5:0] SEL_START = 6'b100000;
  localparam logic [5:0] SEL_PLAY  = 6'b010000;
  localparam logic [5:0] SEL_PLAYR = 6'b010001;
  localparam logic [5:0] SEL_FRZ   = 6'b011000;
  localparam logic [5:0] SEL_GO    = 6'b000100;
  localparam logic [5:0] SEL_WIN   = 6'b000010;

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [13:0] observed();
    return {starton, playon, freeze, gameoveron, winon, round_init, lives, level};
  endfunction

  task automatic push(input string tag, input logic [5:0] sel,
                      input logic [3:0] lv, input logic [3:0] lvl);
    exp_t e;
    e.tag = tag;
    e.v   = {sel, lv, lvl};
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t        e;
    logic [13:0] o;
    e = sb.pop_front();
    o = observed();
    total++;
    assert (o === e.v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (sel|lives|level)", e.tag, o, e.v);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expectation is queued with the stimulus, then checked after the edge.
  task automatic step(input string tag, input logic [5:0] sel,
                      input logic [3:0] lv, input logic [3:0] lvl);
    push(tag, sel, lv, lvl);
    tick();
    compare();
  endtask

  task automatic look(input string tag, input logic [5:0] sel,
                      input logic [3:0] lv, input logic [3:0] lvl);
    push(tag, sel, lv, lvl);
    compare();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n     = 1'b0;
    keycode     = 8'h2c;
    life_lost   = 1'b0;
    level_clear = 1'b0;

    // Reset state, start key held from cycle 0
    #12;
    look("reset", SEL_START, 4'd3, 4'd0);
    Reset_n = 1'b1;
    step("held_key_cooldown", SEL_START, 4'd3, 4'd0);
    for (int i = 0; i < 10; i++) step($sformatf("held_key_%0d", i), SEL_START, 4'd3, 4'd0);
    keycode = 8'h00;
    step("start_release", SEL_START, 4'd3, 4'd0);
    keycode = 8'h2c;
    step("start_press", SEL_PLAYR, 4'd3, 4'd0);
    keycode = 8'h00;
    step("round_init_1cyc", SEL_PLAY, 4'd3, 4'd0);

    // Lives: two respawns, then game over
    for (int k = 0; k < 2; k++) begin
      life_lost = 1'b1;
      step($sformatf("life_lost_%0d", k), SEL_FRZ, 4'(2 - k), 4'd0);
      life_lost = 1'b0;
      for (int i = 1; i < 64; i++)
        step($sformatf("respawn_%0d_%0d", k, i), SEL_FRZ, 4'(2 - k), 4'd0);
      step($sformatf("respawn_exit_%0d", k), SEL_PLAYR, 4'(2 - k), 4'd0);
      step($sformatf("respawn_play_%0d", k), SEL_PLAY, 4'(2 - k), 4'd0);
    end
    life_lost = 1'b1;
    step("gameover", SEL_GO, 4'd0, 4'd0);
    step("no_underflow", SEL_GO, 4'd0, 4'd0);
    life_lost = 1'b0;

    // Back to start; a press during cooldown is ignored
    keycode = 8'h2c;
    step("go_to_start", SEL_START, 4'd0, 4'd0);
    keycode = 8'h00;
    step("cool_release", SEL_START, 4'd0, 4'd0);
    keycode = 8'h2c;
    step("cool_press_ignored", SEL_START, 4'd0, 4'd0);
    keycode = 8'h00;
    for (int i = 0; i < 6; i++) step($sformatf("cool_wait_%0d", i), SEL_START, 4'd0, 4'd0);
    keycode = 8'h2c;
    step("restart", SEL_PLAYR, 4'd3, 4'd0);
    keycode = 8'h00;
    step("restart_play", SEL_PLAY, 4'd3, 4'd0);

    // Levels up to a win
    for (int k = 1; k < 4; k++) begin
      level_clear = 1'b1;
      step($sformatf("level_up_%0d", k), SEL_PLAYR, 4'd3, 4'(k));
      level_clear = 1'b0;
      step($sformatf("level_play_%0d", k), SEL_PLAY, 4'd3, 4'(k));
    end
    level_clear = 1'b1;
    step("win", SEL_WIN, 4'd3, 4'd3);
    step("level_capped", SEL_WIN, 4'd3, 4'd3);
    level_clear = 1'b0;
    keycode = 8'h2c;
    step("win_to_start", SEL_START, 4'd3, 4'd3);
    keycode = 8'h00;
    for (int i = 0; i < 8; i++) step($sformatf("win_cool_%0d", i), SEL_START, 4'd3, 4'd3);
    keycode = 8'h2c;
    step("replay", SEL_PLAYR, 4'd3, 4'd0);
    keycode = 8'h00;
    step("replay_play", SEL_PLAY, 4'd3, 4'd0);

    // Pause
    keycode = 8'h13;
    step("pause", SEL_FRZ, 4'd3, 4'd0);
    life_lost   = 1'b1;
    level_clear = 1'b1;
    step("pause_ignores", SEL_FRZ, 4'd3, 4'd0);
    life_lost   = 1'b0;
    level_clear = 1'b0;
    keycode = 8'h00;
    step("pause_release", SEL_FRZ, 4'd3, 4'd0);
    keycode = 8'h13;
    step("unpause", SEL_PLAY, 4'd3, 4'd0);
    keycode = 8'h00;
    step("unpause_release", SEL_PLAY, 4'd3, 4'd0);
    keycode = 8'h13;
    step("hold_pause", SEL_FRZ, 4'd3, 4'd0);
    for (int i = 1; i < 100; i++) step($sformatf("hold_pause_%0d", i), SEL_FRZ, 4'd3, 4'd0);
    keycode = 8'h00;
    step("hold_release", SEL_FRZ, 4'd3, 4'd0);
    keycode = 8'h2c;
    step("resume_start_key", SEL_PLAY, 4'd3, 4'd0);
    keycode = 8'h00;
    step("resume_play", SEL_PLAY, 4'd3, 4'd0);

    // Simultaneous life_lost and level_clear at level 1
    level_clear = 1'b1;
    step("level1", SEL_PLAYR, 4'd3, 4'd1);
    level_clear = 1'b0;
    step("level1_play", SEL_PLAY, 4'd3, 4'd1);
    life_lost   = 1'b1;
    level_clear = 1'b1;
    step("both_pulses", SEL_FRZ, 4'd2, 4'd1);
    life_lost   = 1'b0;
    level_clear = 1'b0;
    for (int i = 0; i < 3; i++) step($sformatf("respawn_hold_%0d", i), SEL_FRZ, 4'd2, 4'd1);

    // Asynchronous reset between edges
    #3;
    Reset_n = 1'b0;
    #1;
    look("async_reset", SEL_START, 4'd3, 4'd0);
    step("reset_held", SEL_START, 4'd3, 4'd0);
    Reset_n = 1'b1;
    step("after_reset", SEL_START, 4'd3, 4'd0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
